// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: request/status bundle between a FIFO user and its pointer controller
interface fifo_ctrl_if #(parameter int DEPTH = 4, parameter int AW = 2);
  logic PUSH;
  logic POP;
  logic CLEAR;
  logic [DEPTH-1:0] LOAD_EN;
  logic [AW-1:0] RD_SEL;
  logic [AW:0] COUNT;
  logic FULL;
  logic EMPTY;
  logic OVF;
  logic UDF;
  modport master (output PUSH, POP, CLEAR, input LOAD_EN, RD_SEL, COUNT, FULL, EMPTY, OVF, UDF);
  modport slave (input PUSH, POP, CLEAR, output LOAD_EN, RD_SEL, COUNT, FULL, EMPTY, OVF, UDF);
endinterface

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/count controller steering LOAD strobes and read select for a DEPTH-entry register bank
module fifo_ctrl #(parameter int DEPTH = 4, parameter int AW = 2) (
  input logic clk,
  input logic rst,
  fifo_ctrl_if.slave bus
);
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic pop_ok, push_ok;
  assign pop_ok = bus.POP && !bus.EMPTY;
  // a pop in the same cycle frees the slot, so a full FIFO still takes the push
  assign push_ok = bus.PUSH && (!bus.FULL || pop_ok);
  assign bus.LOAD_EN = (push_ok && !bus.CLEAR && rst) ? DEPTH'(1) << wr_ptr : '0;
  assign bus.RD_SEL = rd_ptr;
  assign bus.FULL = bus.COUNT == (AW+1)'(DEPTH);
  assign bus.EMPTY = bus.COUNT == '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      bus.COUNT <= '0;
      bus.OVF <= 1'b0;
      bus.UDF <= 1'b0;
    end else if (bus.CLEAR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      bus.COUNT <= '0;
      bus.OVF <= 1'b0;
      bus.UDF <= 1'b0;
    end else begin
      wr_ptr <= push_ok ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop_ok ? rd_ptr + AW'(1) : rd_ptr;
      bus.COUNT <= bus.COUNT + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      bus.OVF <= bus.OVF | (bus.PUSH & ~push_ok);
      bus.UDF <= bus.UDF | (bus.POP & bus.EMPTY);
    end
endmodule
